match_router: RTL and testbench
===============================

MATCH_ROUTER -- requirements
Module: match_router

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, character width in bits.
REQ-002 SHALL have parameter num, default 16, lanes per group.
REQ-003 SHALL have parameter groups, default 16, number of lane groups.
REQ-004 SHALL have parameter max_number_of_weight, default num*groups, total lane count N.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port router_input, input, N*DWIDTH, lane i character at bits [i*DWIDTH +: DWIDTH].
REQ-008 SHALL have port alu, input, 2*N, lane i opcode at bits [i*2 +: 2].
REQ-009 SHALL have port en, input, N, lane i enable.
REQ-010 SHALL have port router_output, output, N, registered per-lane match flags.
REQ-011 SHALL have port match_count, output, 16, saturating total of asserted router_output bits.

Function
REQ-012 Each lane SHALL hold head[i] (DWIDTH), cmp[i] (DWIDTH) and armed[i] (1 bit).
REQ-013 Lanes SHALL operate independently; one lane's opcode SHALL NOT affect another lane's state.
REQ-014 alu=2'b00 (LOAD_HEAD): head[i] <= router_input lane i and armed[i] <= 0, regardless of en[i]; router_output[i] <= 0.
REQ-015 alu=2'b01 (COMPARE) with en[i]=1 and armed[i]=1: router_output[i] <= (lane char == cmp[i]); armed[i] <= 0.
REQ-016 alu=2'b01 with en[i]=1 and armed[i]=0: router_output[i] <= (lane char == head[i]).
REQ-017 alu=2'b10 (LOAD_CMP) with en[i]=1: cmp[i] <= lane char; armed[i] <= 1; router_output[i] <= 0.
REQ-018 alu=2'b11 (CLEAR): armed[i] <= 0; router_output[i] <= 0; head[i] and cmp[i] unchanged.
REQ-019 Any opcode other than LOAD_HEAD and CLEAR, with en[i]=0: router_output[i] <= 0; head, cmp and armed unchanged.
REQ-020 Latency SHALL be exactly 1 cycle: inputs sampled at edge k appear on router_output after edge k.
REQ-021 router_output[i] SHALL be a single-cycle pulse per qualifying COMPARE; it SHALL NOT hold without a new COMPARE.
REQ-022 An armed lane SHALL consume its arming on the first enabled COMPARE, match or miss; the following COMPARE uses head[i].
REQ-023 LOAD_CMP on an already-armed lane SHALL overwrite cmp[i]; armed stays 1.
REQ-024 Each cycle, match_count SHALL add the population count of the router_output value being registered.
REQ-025 match_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-026 Comparison SHALL be exact DWIDTH-bit equality; character value 0 SHALL be a legal match.

Reset
REQ-027 When reset=1 at a rising edge: router_output <= 0, match_count <= 0, and head, cmp and armed of every lane <= 0; all inputs ignored.
REQ-028 reset asserted mid-sequence SHALL discard pending arming; the first post-reset COMPARE SHALL use head=0.
REQ-029 Reset SHALL take priority over every opcode in the same cycle.

Verification
REQ-030 LOAD_HEAD lane0=8'h61, then COMPARE en[0]=1 char 8'h61 -> router_output[0]=1 for one cycle, match_count=1; next cycle char 8'h62 -> router_output[0]=0.
REQ-031 Lane3: head=8'h41, LOAD_CMP 8'h42, COMPARE 8'h42 -> match; next COMPARE 8'h42 -> 0 (arming consumed, head used).
REQ-032 All N lanes: head=8'h7A, COMPARE 8'h7A with en all ones -> router_output all ones, match_count=N; repeat until count reaches 16'hFFFF and holds.
REQ-033 Lane5 COMPARE with en[5]=0 and matching char -> router_output[5]=0, armed[5] unchanged (a later enabled COMPARE uses cmp).
REQ-034 Arm lane2, assert reset for one cycle, COMPARE 8'h00 en[2]=1 -> router_output[2]=1, match_count=1.
REQ-035 Mixed opcodes in one cycle (lane0 LOAD_HEAD, lane1 COMPARE hit, lane2 CLEAR, lane3 LOAD_CMP) -> only router_output[1]=1, per-lane state updated per REQ-014..REQ-018.

Source files
------------

// File: rtl/match_router.sv
// Per-lane character match router: each lane compares its input character against
// a stored head or a one-shot armed compare value, with a saturating hit counter.
module match_router #(
  parameter int DWIDTH               = 8,
  parameter int num                  = 16,
  parameter int groups               = 16,
  parameter int max_number_of_weight = num * groups
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [max_number_of_weight*DWIDTH-1:0] router_input,
  input  logic [2*max_number_of_weight-1:0]      alu,
  input  logic [max_number_of_weight-1:0]        en,
  output logic [max_number_of_weight-1:0]        router_output,
  output logic [15:0]                            match_count
);

  localparam int N  = max_number_of_weight;
  localparam int NG = (N + num - 1) / num;
  localparam int GW = $clog2(num + 1);
  localparam int TW = $clog2(N + 1);

  typedef enum logic [1:0] {
    OP_LOAD_HEAD = 2'b00,
    OP_COMPARE   = 2'b01,
    OP_LOAD_CMP  = 2'b10,
    OP_CLEAR     = 2'b11
  } op_t;

  logic [N-1:0][DWIDTH-1:0] lane_char;
  logic [N-1:0][1:0]        lane_op;

  logic [N-1:0][DWIDTH-1:0] head;
  logic [N-1:0][DWIDTH-1:0] cmp;
  logic [N-1:0]             armed;

  logic [N-1:0][DWIDTH-1:0] head_next;
  logic [N-1:0][DWIDTH-1:0] cmp_next;
  logic [N-1:0]             armed_next;
  logic [N-1:0]             out_next;

  logic [NG-1:0][GW-1:0]    group_count;
  logic [TW-1:0]            pop_total;
  logic [16:0]              count_sum;
  logic [15:0]              count_next;

  assign lane_char = router_input;
  assign lane_op   = alu;

  always_comb begin
    head_next  = head;
    cmp_next   = cmp;
    armed_next = armed;
    out_next   = '0;
    for (int i = 0; i < N; i++) begin
      unique case (op_t'(lane_op[i]))
        OP_LOAD_HEAD: begin
          head_next[i]  = lane_char[i];
          armed_next[i] = 1'b0;
        end
        OP_COMPARE: begin
          if (en[i]) begin
            // An armed lane spends its one-shot compare value, hit or miss.
            if (armed[i]) begin
              out_next[i]   = (lane_char[i] == cmp[i]);
              armed_next[i] = 1'b0;
            end else begin
              out_next[i] = (lane_char[i] == head[i]);
            end
          end
        end
        OP_LOAD_CMP: begin
          if (en[i]) begin
            cmp_next[i]   = lane_char[i];
            armed_next[i] = 1'b1;
          end
        end
        OP_CLEAR: begin
          armed_next[i] = 1'b0;
        end
        default: begin
          armed_next[i] = armed[i];
        end
      endcase
    end
  end

  // Population count is summed per lane group first to keep the adder tree shallow.
  always_comb begin
    group_count = '0;
    for (int g = 0; g < NG; g++) begin
      for (int l = 0; l < num; l++) begin
        if (g * num + l < N) begin
          group_count[g] = group_count[g] + GW'(out_next[(g * num + l) % N]);
        end
      end
    end
  end

  always_comb begin
    pop_total = '0;
    for (int g = 0; g < NG; g++) begin
      pop_total = pop_total + TW'(group_count[g]);
    end
  end

  always_comb begin
    count_sum  = {1'b0, match_count} + 17'(pop_total);
    count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      cmp           <= '0;
      armed         <= '0;
      router_output <= '0;
      match_count   <= '0;
    end else begin
      head          <= head_next;
      cmp           <= cmp_next;
      armed         <= armed_next;
      router_output <= out_next;
      match_count   <= count_next;
    end
  end

endmodule

// File: tb/tb_match_router.sv
// Self-checking bench for match_router: directed scenarios plus randomized traffic
// checked against a lane-by-lane behavioural model.
module tb_match_router;

  localparam int DW = 8;
  localparam int N  = 256;

  logic              clk;
  logic              reset;
  logic [N*DW-1:0]   router_input;
  logic [2*N-1:0]    alu;
  logic [N-1:0]      en;
  logic [N-1:0]      router_output;
  logic [15:0]       match_count;

  int checks;
  int passed;

  logic [7:0]   m_head  [N];
  logic [7:0]   m_cmp   [N];
  bit           m_armed [N];
  logic [N-1:0] m_out;
  int           m_count;

  match_router #(
    .DWIDTH(8),
    .num(16),
    .groups(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .router_input(router_input),
    .alu(alu),
    .en(en),
    .router_output(router_output),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: applies the opcode rules to the inputs held across the last edge.
  task automatic model_step();
    logic [1:0] op;
    logic [7:0] ch;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_head[i]  = 8'h00;
        m_cmp[i]   = 8'h00;
        m_armed[i] = 1'b0;
      end
      m_out   = '0;
      m_count = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        op       = alu[2*i +: 2];
        ch       = router_input[i*DW +: DW];
        m_out[i] = 1'b0;
        if (op == 2'b00) begin
          m_head[i]  = ch;
          m_armed[i] = 1'b0;
        end else if (op == 2'b11) begin
          m_armed[i] = 1'b0;
        end else if (en[i]) begin
          if (op == 2'b01) begin
            m_out[i]   = m_armed[i] ? (ch == m_cmp[i]) : (ch == m_head[i]);
            m_armed[i] = 1'b0;
          end else begin
            m_cmp[i]   = ch;
            m_armed[i] = 1'b1;
          end
        end
      end
      m_count = m_count + $countones(m_out);
      if (m_count > 65535) m_count = 65535;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic set_idle();
    reset        = 1'b0;
    alu          = {N{2'b01}};
    en           = '0;
    router_input = '0;
  endtask

  task automatic set_lane(input int i, input logic [1:0] op, input logic e, input logic [7:0] ch);
    alu[2*i +: 2]            = op;
    en[i]                    = e;
    router_input[i*DW +: DW] = ch;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    for (int i = 0; i < N; i++) set_lane(i, 2'($urandom_range(0, 3)), 1'b1, 8'h00);
    reset = 1'b1;
    tick();
    set_idle();
    checks++;
    if (router_output !== '0) $display("[TB] FAIL reset_out: got %h required 0", router_output);
    else passed++;
    checks++;
    if (match_count !== 16'h0000) $display("[TB] FAIL reset_count: got %h required 0000", match_count);
    else passed++;
  endtask

  task automatic test_compare_head();
    do_reset();
    set_lane(0, 2'b00, 1'b0, 8'h61);
    tick();
    checks++;
    if (router_output !== '0) $display("[TB] FAIL load_head_out: got %h required 0", router_output);
    else passed++;
    set_idle();
    set_lane(0, 2'b01, 1'b1, 8'h61);
    tick();
    checks++;
    if (router_output[0] !== 1'b1 || router_output !== m_out)
      $display("[TB] FAIL head_hit: got %h required %h", router_output, m_out);
    else passed++;
    checks++;
    if (match_count !== 16'd1) $display("[TB] FAIL head_hit_count: got %0d required 1", match_count);
    else passed++;
    set_lane(0, 2'b01, 1'b1, 8'h62);
    tick();
    checks++;
    if (router_output !== '0) $display("[TB] FAIL head_miss: got %h required 0", router_output);
    else passed++;
    checks++;
    if (match_count !== 16'd1) $display("[TB] FAIL head_miss_count: got %0d required 1", match_count);
    else passed++;
  endtask

  task automatic test_arm_consume();
    do_reset();
    set_lane(3, 2'b00, 1'b0, 8'h41); tick();
    set_lane(3, 2'b10, 1'b1, 8'h42); tick();
    set_lane(3, 2'b01, 1'b1, 8'h42); tick();
    checks++;
    if (router_output !== (N'(1) << 3)) $display("[TB] FAIL arm_hit: got %h required %h", router_output, N'(1) << 3);
    else passed++;
    tick();
    checks++;
    if (router_output !== '0) $display("[TB] FAIL arm_consumed: got %h required 0", router_output);
    else passed++;
    set_lane(3, 2'b10, 1'b1, 8'h50); tick();
    set_lane(3, 2'b10, 1'b1, 8'h51); tick();
    set_lane(3, 2'b01, 1'b1, 8'h51); tick();
    checks++;
    if (router_output !== (N'(1) << 3) || match_count !== 16'd2)
      $display("[TB] FAIL rearm_overwrite: got %h/%0d required %h/2", router_output, match_count, N'(1) << 3);
    else passed++;
  endtask

  task automatic test_disabled();
    do_reset();
    set_lane(5, 2'b00, 1'b0, 8'h10); tick();
    set_lane(5, 2'b10, 1'b1, 8'h20); tick();
    set_lane(5, 2'b01, 1'b0, 8'h20); tick();
    checks++;
    if (router_output !== '0) $display("[TB] FAIL disabled_compare: got %h required 0", router_output);
    else passed++;
    set_lane(5, 2'b01, 1'b1, 8'h20); tick();
    checks++;
    if (router_output !== (N'(1) << 5)) $display("[TB] FAIL disabled_keeps_arm: got %h required %h", router_output, N'(1) << 5);
    else passed++;
  endtask

  task automatic test_reset_arming();
    do_reset();
    set_lane(2, 2'b00, 1'b0, 8'h33); tick();
    set_lane(2, 2'b10, 1'b1, 8'h44); tick();
    set_lane(2, 2'b01, 1'b1, 8'h44);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (router_output !== '0 || match_count !== 16'd0)
      $display("[TB] FAIL reset_priority: got %h/%0d required 0/0", router_output, match_count);
    else passed++;
    set_lane(2, 2'b01, 1'b1, 8'h00); tick();
    checks++;
    if (router_output !== (N'(1) << 2) || match_count !== 16'd1)
      $display("[TB] FAIL post_reset_zero: got %h/%0d required %h/1", router_output, match_count, N'(1) << 2);
    else passed++;
  endtask

  task automatic test_mixed();
    do_reset();
    set_lane(1, 2'b00, 1'b0, 8'h55);
    set_lane(2, 2'b10, 1'b1, 8'h66);
    tick();
    set_idle();
    set_lane(0, 2'b00, 1'b0, 8'h99);
    set_lane(1, 2'b01, 1'b1, 8'h55);
    set_lane(2, 2'b11, 1'b1, 8'h66);
    set_lane(3, 2'b10, 1'b1, 8'h77);
    tick();
    checks++;
    if (router_output !== (N'(1) << 1)) $display("[TB] FAIL mixed_ops: got %h required %h", router_output, N'(1) << 1);
    else passed++;
    set_idle();
    set_lane(0, 2'b01, 1'b1, 8'h99);
    set_lane(2, 2'b01, 1'b1, 8'h66);
    set_lane(3, 2'b01, 1'b1, 8'h77);
    tick();
    checks++;
    if (router_output !== N'(9) || router_output !== m_out)
      $display("[TB] FAIL mixed_state: got %h required %h", router_output, N'(9));
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) set_lane(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (router_output !== m_out) $display("[TB] FAIL random_out c=%0d: got %h required %h", c, router_output, m_out);
      else passed++;
      checks++;
      if (match_count !== 16'(m_count)) $display("[TB] FAIL random_count c=%0d: got %0d required %0d", c, match_count, m_count);
      else passed++;
    end
    set_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 2'b00, 1'b0, 8'h7A);
    tick();
    for (int i = 0; i < N; i++) set_lane(i, 2'b01, 1'b1, 8'h7A);
    for (int c = 0; c < 260; c++) begin
      tick();
      checks++;
      if (router_output !== {N{1'b1}} || match_count !== 16'(m_count))
        $display("[TB] FAIL saturate c=%0d: got %h/%0d required all ones/%0d", c, router_output, match_count, m_count);
      else passed++;
    end
    tick();
    checks++;
    if (match_count !== 16'hFFFF) $display("[TB] FAIL saturate_hold: got %h required FFFF", match_count);
    else passed++;
    set_idle();
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    m_count = 0;
    m_out   = '0;
    set_idle();
    for (int i = 0; i < N; i++) begin
      m_head[i]  = 8'h00;
      m_cmp[i]   = 8'h00;
      m_armed[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_compare_head();
    test_arm_consume();
    test_disabled();
    test_reset_arming();
    test_mixed();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
